flash_read_master: RTL and testbench

FLASH_READ_MASTER -- requirements
Module: flash_read_master

---
 rtl/flash_read_pkg.sv | 32 +++
 rtl/spi_shift_engine.sv | 80 ++++++++
 rtl/flash_read_master.sv | 165 ++++++++++++++++
 tb/tb_flash_read_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_read_pkg.sv
// rtl/flash_read_pkg.sv - shared constants, FSM state type and byte-order helper for the SPI flash read master
// Contents:
//   OP_READ / OP_WAKE    flash opcodes (normal read, release from power-down)
//   LEN_CMD/ADDR/DATA    bit lengths of each shifted phase
//   state_t              read master FSM states
//   swap_bytes()         maps the MSB-first 32-bit shift result to little-endian word order
package flash_read_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WAKE = 8'hAB;

    localparam logic [5:0] LEN_CMD  = 6'd8;
    localparam logic [5:0] LEN_ADDR = 6'd24;
    localparam logic [5:0] LEN_DATA = 6'd32;

    typedef enum logic [2:0] {
        ST_WAKE,
        ST_WAKE_GAP,
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_GAP
    } state_t;

    // The first byte shifted in (lowest address) lands in the top byte of the
    // shift register; it belongs in the bottom byte of the returned word.
    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI mode-0 shift engine with programmable SCK half-period
// Ports:
//   clk, resetn      system clock, synchronous active-low reset
//   start            load tx_data/nbits and begin shifting (may coincide with bit_done to chain phases)
//   nbits            number of bits in this phase (1..32)
//   tx_data          bits to send, MSB-aligned, MSB first
//   miso             serial input, sampled on the clk edge that raises sck
//   sck              SPI clock, idle low
//   mosi             serial output, changes only while sck is low, 0 when idle
//   bit_done         strobe on the clk edge that ends the last bit of the phase (sck falling)
//   rx_data          last 32 bits sampled from miso, most recent in bit 0
import flash_read_pkg::*;

module spi_shift_engine #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [5:0]  nbits,
    input  logic [31:0] tx_data,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        bit_done,
    output logic [31:0] rx_data
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic        busy;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] shreg;
    logic        tick;

    // tick marks the clk edge on which sck toggles
    assign tick     = busy && (div_cnt == DIV_LAST);
    assign bit_done = tick && sck && (bit_cnt == 6'd1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            rx_data <= '0;
        end else if (start) begin
            // Loading restarts the divider with sck low, so the first bit
            // gets a full half-period of setup before its rising edge.
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= nbits;
            shreg   <= tx_data;
            sck     <= 1'b0;
            mosi    <= tx_data[31];
        end else if (busy) begin
            if (tick) begin
                div_cnt <= '0;
                sck     <= ~sck;
                if (!sck) begin
                    rx_data <= {rx_data[30:0], miso};
                end else begin
                    bit_cnt <= bit_cnt - 6'd1;
                    shreg   <= {shreg[30:0], 1'b0};
                    mosi    <= shreg[30];
                    if (bit_cnt == 6'd1) begin
                        busy <= 1'b0;
                        mosi <= 1'b0;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/flash_read_master.sv
// rtl/flash_read_master.sv - reads one 32-bit little-endian word per request from a SPI NOR flash (0x03 read)
// Ports:
//   clk, resetn               system clock, synchronous active-low reset
//   req_valid/req_ready       request handshake, req_addr (24-bit byte address) captured on accept
//   rsp_valid/rsp_data        one-cycle response pulse with the word; rsp_data holds until the next pulse
//   flash_csb, flash_clk      chip select (active low), SPI clock (mode 0)
//   flash_io0 / flash_io1     MOSI / MISO
import flash_read_pkg::*;

module flash_read_master #(
    parameter int CLK_DIV       = 1,
    parameter bit WAKE_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    localparam logic [8:0] GAP_LAST    = 9'(2 * CLK_DIV - 1);
    localparam state_t     RESET_STATE = WAKE_ON_RESET ? ST_WAKE : ST_IDLE;

    state_t      state_q, state_d;
    logic [8:0]  gap_cnt;
    logic        launch_q;
    logic        ready_q;
    logic        accept;
    logic [23:0] addr_q;
    logic        csb_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;

    logic        eng_start;
    logic [5:0]  eng_nbits;
    logic [31:0] eng_tx;
    logic        eng_mosi;
    logic        eng_done;
    logic [31:0] eng_rx;

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
        .clk      (clk),
        .resetn   (resetn),
        .start    (eng_start),
        .nbits    (eng_nbits),
        .tx_data  (eng_tx),
        .miso     (flash_io1),
        .sck      (flash_clk),
        .mosi     (eng_mosi),
        .bit_done (eng_done),
        .rx_data  (eng_rx)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // launch_q is high for the first cycle of WAKE/CMD and kicks the engine;
    // that extra cycle is the setup slot between accept and csb falling.
    // Later phases are chained on bit_done so SCK runs without a pause.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        eng_start = 1'b0;
        eng_nbits = LEN_CMD;
        eng_tx    = '0;
        case (state_q)
            ST_WAKE: begin
                if (launch_q) begin
                    eng_start = 1'b1;
                    eng_tx    = {OP_WAKE, 24'h0};
                end else if (eng_done) begin
                    state_d = ST_WAKE_GAP;
                end
            end
            ST_WAKE_GAP, ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    accept  = 1'b1;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (launch_q) begin
                    eng_start = 1'b1;
                    eng_tx    = {OP_READ, 24'h0};
                end else if (eng_done) begin
                    eng_start = 1'b1;
                    eng_nbits = LEN_ADDR;
                    eng_tx    = {addr_q, 8'h0};
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (eng_done) begin
                    eng_start = 1'b1;
                    eng_nbits = LEN_DATA;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (eng_done) begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            launch_q    <= WAKE_ON_RESET;
            ready_q     <= 1'b0;
            gap_cnt     <= '0;
            addr_q      <= '0;
            csb_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            launch_q    <= accept;
            ready_q     <= (state_d == ST_IDLE);
            rsp_valid_q <= 1'b0;
            if ((state_q == ST_GAP || state_q == ST_WAKE_GAP) && state_d == state_q) begin
                gap_cnt <= gap_cnt + 9'd1;
            end else begin
                gap_cnt <= '0;
            end
            if (accept) begin
                addr_q <= req_addr;
            end
            if (eng_start) begin
                csb_q <= 1'b0;
            end else if (eng_done && (state_q == ST_DATA || state_q == ST_WAKE)) begin
                csb_q <= 1'b1;
            end
            if (eng_done && state_q == ST_DATA) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= swap_bytes(eng_rx);
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign flash_csb = csb_q;
    assign flash_io0 = eng_mosi & ~csb_q;

endmodule

// File: tb/tb_flash_read_master.sv
// tb/tb_flash_read_master.sv - scoreboard bench for flash_read_master at CLK_DIV=1 and CLK_DIV=3
module tb_flash_read_master;

    typedef struct {
        bit          wake;
        logic [23:0] addr;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic void chk_true(input string nm, input bit cond, input longint act, input longint req);
        total++;
        if (!cond) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endfunction

    // Flash array contents; 0x10..0x13 hold 11 22 33 44.
    function automatic logic [7:0] fb(input logic [23:0] a);
        case (a)
            24'h000010: fb = 8'h11;
            24'h000011: fb = 8'h22;
            24'h000012: fb = 8'h33;
            24'h000013: fb = 8'h44;
            default:    fb = (a[7:0] * 8'd37) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'hC5;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [23:0] a);
        return {fb(a + 24'd3), fb(a + 24'd2), fb(a + 24'd1), fb(a)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int D = (g == 0) ? 1 : 3;

        logic        resetn = 1'b0;
        logic        req_valid = 1'b0;
        logic [23:0] req_addr = '0;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        csb;
        logic        sck;
        logic        io0;
        logic        io1 = 1'b0;

        txn_t txn_q[$];
        rsp_t rsp_q[$];

        flash_read_master #(.CLK_DIV(D), .WAKE_ON_RESET(1'b1)) dut (
            .clk       (clk),
            .resetn    (resetn),
            .req_valid (req_valid),
            .req_addr  (req_addr),
            .req_ready (req_ready),
            .rsp_valid (rsp_valid),
            .rsp_data  (rsp_data),
            .flash_csb (csb),
            .flash_clk (sck),
            .flash_io0 (io0),
            .flash_io1 (io1)
        );

        // Flash model plus monitor: decodes the io0 stream, serves data on io1,
        // checks SPI timing and pops the scoreboard queues.
        int          bits = 0;
        int          lt = 0;
        int          lc = 0;
        int          rise_c = -1000000;
        logic        p_csb = 1'b1;
        logic        p_sck = 1'b0;
        logic        p_io0 = 1'b0;
        logic [63:0] stream = '0;
        logic [23:0] faddr = '0;

        always begin
            @(posedge clk);
            #1;
            if (io0 !== p_io0) lc = cyc;
            if (csb) chk($sformatf("d%0d idle_lines", D), {62'd0, sck, io0}, 64'd0);
            if (p_csb && !csb) begin
                chk_true($sformatf("d%0d csb_high_time", D), (cyc - rise_c) >= 2 * D, cyc - rise_c, 2 * D);
                bits   = 0;
                stream = '0;
                lt     = cyc;
            end
            if (!csb && sck !== p_sck) begin
                chk($sformatf("d%0d half_period", D), 64'(cyc - lt), 64'(D));
                lt = cyc;
                if (sck) begin
                    chk_true($sformatf("d%0d io0_setup", D), (cyc - lc) >= D, cyc - lc, D);
                    if (bits >= 32) chk($sformatf("d%0d io0_data_zero", D), {63'd0, io0}, 64'd0);
                    stream = {stream[62:0], io0};
                    bits++;
                    if (bits == 32) faddr = stream[23:0];
                end else if (bits >= 32 && bits < 64) begin
                    automatic int k = bits - 32;
                    automatic logic [7:0] b = fb(faddr + 24'(k / 8));
                    io1 = b[7 - (k % 8)];
                end
            end
            if (!p_csb && csb) begin
                rise_c = cyc;
                if (!resetn) begin
                    if (txn_q.size() > 0) void'(txn_q.pop_front());
                end else if (txn_q.size() == 0) begin
                    chk_true($sformatf("d%0d unexpected_txn", D), 1'b0, bits, 0);
                end else begin
                    automatic txn_t t = txn_q.pop_front();
                    if (t.wake) begin
                        chk($sformatf("d%0d wake_bits", D), 64'(bits), 64'd8);
                        chk($sformatf("d%0d wake_stream", D), {56'd0, stream[7:0]}, 64'hAB);
                    end else begin
                        chk($sformatf("d%0d read_bits", D), 64'(bits), 64'd64);
                        chk($sformatf("d%0d read_header", D), {32'd0, stream[63:32]}, {32'd0, 8'h03, t.addr});
                    end
                end
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk_true($sformatf("d%0d unexpected_rsp", D), 1'b0, rsp_data, 0);
                end else begin
                    automatic rsp_t r = rsp_q.pop_front();
                    chk($sformatf("d%0d rsp_data", D), {32'd0, rsp_data}, {32'd0, r.data});
                    chk($sformatf("d%0d rsp_cycle", D), 64'(cyc), 64'(r.cyc));
                end
            end
            p_csb = csb;
            p_sck = sck;
            p_io0 = io0;
        end

        task automatic wait_ready();
            int n = 0;
            while (!req_ready && n < 5000) begin
                @(negedge clk);
                n++;
            end
            chk_true($sformatf("d%0d ready_wait", D), req_ready === 1'b1, n, 5000);
        endtask

        task automatic do_reset();
            int r;
            @(negedge clk);
            resetn = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("d%0d rst_lines", D), {59'd0, csb, sck, io0, req_ready, rsp_valid}, 64'b10000);
            chk($sformatf("d%0d rst_rsp_data", D), {32'd0, rsp_data}, 64'd0);
            repeat (9) @(posedge clk);
            txn_q.delete();
            rsp_q.delete();
            @(negedge clk);
            txn_q.push_back('{wake: 1'b1, addr: 24'h0});
            resetn = 1'b1;
            r = cyc + 1;
            wait_ready();
            chk($sformatf("d%0d wake_ready_cycle", D), 64'(cyc), 64'(r + 18 * D));
        endtask

        task automatic do_read(input logic [23:0] a, input logic [31:0] exp_data, output int acc);
            @(negedge clk);
            wait_ready();
            req_valid = 1'b1;
            req_addr  = a;
            acc = cyc + 1;
            txn_q.push_back('{wake: 1'b0, addr: a});
            rsp_q.push_back('{data: exp_data, cyc: acc + 1 + 128 * D});
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = 24'($urandom);
        endtask

        task automatic wait_bits(input int nb);
            int n = 0;
            repeat (2) @(negedge clk);
            while (!(csb === 1'b0 && bits >= nb) && n < 5000) begin
                @(negedge clk);
                n++;
            end
            chk_true($sformatf("d%0d bits_wait", D), bits >= nb, bits, nb);
        endtask

        initial begin
            int a1, a2, acc;
            logic [23:0] ra;

            do_reset();

            do_read(24'h000010, 32'h44332211, acc);

            // Back-to-back with req_valid held high across both accepts.
            @(negedge clk);
            wait_ready();
            req_valid = 1'b1;
            req_addr  = 24'h000000;
            a1 = cyc + 1;
            txn_q.push_back('{wake: 1'b0, addr: 24'h000000});
            rsp_q.push_back('{data: word_at(24'h000000), cyc: a1 + 1 + 128 * D});
            @(negedge clk);
            req_addr = 24'h000004;
            wait_ready();
            a2 = cyc + 1;
            txn_q.push_back('{wake: 1'b0, addr: 24'h000004});
            rsp_q.push_back('{data: word_at(24'h000004), cyc: a2 + 1 + 128 * D});
            chk($sformatf("d%0d b2b_accept", D), 64'(a2), 64'(a1 + 1 + 128 * D + 2 * D + 1));
            @(negedge clk);
            req_valid = 1'b0;

            // Request noise during DATA must be ignored.
            do_read(24'h000200, word_at(24'h000200), acc);
            wait_bits(40);
            req_valid = 1'b1;
            req_addr  = 24'h000200 ^ 24'h5A5A5A;
            chk($sformatf("d%0d ready_busy", D), {63'd0, req_ready}, 64'd0);
            repeat (20) @(negedge clk);
            req_valid = 1'b0;

            do_read(24'hFFFFFC, word_at(24'hFFFFFC), acc);

            // Abort in the middle of DATA bit 12.
            do_read(24'h00ABCD, word_at(24'h00ABCD), acc);
            wait_bits(44);
            do_reset();
            do_read(24'h000040, word_at(24'h000040), acc);

            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                ra = 24'($urandom);
                do_read(ra, word_at(ra), acc);
            end

            begin
                int n = 0;
                while (rsp_q.size() != 0 && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
            end
            repeat (2) @(negedge clk);
            chk($sformatf("d%0d rsp_drain", D), 64'(rsp_q.size()), 64'd0);
            chk($sformatf("d%0d txn_drain", D), 64'(txn_q.size()), 64'd0);
            done_n++;
        end
    end

    initial begin
        int n = 0;
        while (done_n < 2 && n < 80000) begin
            @(negedge clk);
            n++;
        end
        chk_true("global_timeout", done_n == 2, done_n, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
